trena_uc: RTL and testbench
===========================

# trena_uc

Control unit for the ultrasonic tape-measure datapath. On a `mensurar` request it clears the ASCII character counter, fires one HC-SR04 measurement, and waits for the result. It then transmits the four ASCII characters over the 7E1 serial transmitter one at a time and pulses `pronto` when the last character has left. A watchdog aborts the measurement and raises `erro` if the sensor never answers.

## Interface
- `TIMEOUT_CICLOS`, default 3_000_000: maximum clock cycles spent waiting for `pronto_medida` (60 ms at 50 MHz).
- `TIMEOUT_BITS`, default 22: width of the watchdog counter; must satisfy 2^TIMEOUT_BITS ≥ TIMEOUT_CICLOS.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `mensurar` in 1: start request, level-sampled in `inicial` and `erro` only.
- `pronto_medida` in 1: one-cycle pulse, measurement complete.
- `pronto_transmissao` in 1: one-cycle pulse, one character transmitted.
- `fim_serial` in 1: character counter is at its last value (index 3).
- `zera` out 1: synchronous clear of the character counter.
- `medir` out 1: one-cycle measurement trigger.
- `partida_serial` out 1: one-cycle start of a character transmission.
- `conta_ascii` out 1: one-cycle advance of the character counter.
- `pronto` out 1: one-cycle pulse, full cycle finished.
- `erro` out 1: timeout flag, held while in `erro`.
- `db_estado` out 4: current state code.

## Operation
- Moore FSM. All outputs are decoded from the state register only.
- State codes and actions:
  - `inicial` = 0: no outputs asserted.
  - `preparacao` = 1: `zera` = 1.
  - `medicao` = 2: `medir` = 1.
  - `aguarda_medida` = 3: watchdog counts.
  - `transmissao` = 4: `partida_serial` = 1.
  - `aguarda_transmissao` = 5: waiting for the character to finish.
  - `proximo` = 6: `conta_ascii` = 1.
  - `final` = 7: `pronto` = 1.
  - `erro` = 15: `erro` = 1.
- Transitions:
  - `inicial` → `preparacao` if `mensurar`.
  - `preparacao` → `medicao` unconditionally.
  - `medicao` → `aguarda_medida` unconditionally.
  - `aguarda_medida` → `transmissao` on `pronto_medida`.
  - `aguarda_medida` → `erro` when the watchdog reaches TIMEOUT_CICLOS-1.
  - `transmissao` → `aguarda_transmissao` unconditionally.
  - `aguarda_transmissao` → `final` on `pronto_transmissao` with `fim_serial` = 1.
  - `aguarda_transmissao` → `proximo` on `pronto_transmissao` with `fim_serial` = 0.
  - `proximo` → `transmissao` unconditionally.
  - `final` → `inicial` unconditionally.
  - `erro` → `preparacao` if `mensurar`.
  - Any unused code → `inicial`.
- Watchdog:
  - Cleared in every state other than `aguarda_medida`.
  - Increments by 1 per cycle in `aguarda_medida`. Never wraps.
- `mensurar` is ignored in every state except `inicial` and `erro`.
- A `pronto_medida` or `pronto_transmissao` arriving outside its wait state is ignored.

## Timing
- Reset values: state `inicial`; all outputs 0; `db_estado` = 0; watchdog = 0. Reset mid-operation returns to `inicial` immediately, with no pending pulse completed.
- Start latency: `mensurar` high at cycle N in `inicial` gives `zera` at N+1, `medir` at N+2, and `aguarda_medida` from N+3.
- Measurement result: `pronto_medida` at cycle M gives `partida_serial` at M+1.
- Character completion, `pronto_transmissao` at cycle T:
  - With `fim_serial` = 0: `conta_ascii` at T+1, `partida_serial` at T+2.
  - With `fim_serial` = 1: `pronto` at T+1, `inicial` at T+2.
- Exactly 4 `partida_serial` pulses and 3 `conta_ascii` pulses per successful cycle. `zera` and `medir` each pulse once.
- Timeout: `pronto_medida` absent for TIMEOUT_CICLOS cycles after entering `aguarda_medida` gives `erro` = 1 from the next cycle onward.
- `pronto_medida` in the same cycle as the watchdog terminal count: `pronto_medida` wins and the FSM goes to `transmissao`.
- `mensurar` held high continuously: a new cycle starts from the cycle after `final`, with 2 idle cycles between `pronto` and the next `medir`.

## Structure
- Shared package `trena_pkg`:
  - State code constants (4 bits, values as listed in Operation).
  - Default TIMEOUT_CICLOS.
- Watchdog: instance of the existing `contador_m` with M = TIMEOUT_CICLOS and N = TIMEOUT_BITS.
  - `zera_s` driven by "state ≠ `aguarda_medida`".
  - `conta` driven by "state = `aguarda_medida`".
  - Its `fim` output is the timeout condition.
- FSM: three blocks in this module (state register, next-state logic, output decode).

## Test plan
Bench parameters: TIMEOUT_CICLOS = 20, TIMEOUT_BITS = 5.
- Reset, then `mensurar` pulse at N → `zera` at N+1, `medir` at N+2, `db_estado` = 3 at N+3; all other outputs 0.
- Full cycle: `pronto_medida` pulse, then 4 `pronto_transmissao` pulses with `fim_serial` high only for the 4th → 4 `partida_serial`, 3 `conta_ascii`, one `pronto` one cycle after the 4th pulse, `db_estado` back to 0.
- No `pronto_medida` → `erro` = 1 and `db_estado` = 15 after 20 cycles in `aguarda_medida`. Then a `mensurar` pulse → `erro` drops, `zera` asserted next cycle.
- `pronto_medida` on the watchdog terminal cycle → `partida_serial` next cycle; `erro` never asserted.
- `mensurar` pulsed during `aguarda_transmissao` → ignored, no extra `zera`. Then `reset` asserted mid-transmission → all outputs 0 in the same cycle, state `inicial`.
- `mensurar` held high for 3 cycles in a row → second `medir` exactly 3 cycles after `pronto` (2 idle cycles between them).

Source files
------------

// File: rtl/trena_pkg.sv
// Shared definitions for the ultrasonic tape-measure control unit.
// State codes are fixed because db_estado exposes them on the debug port.
package trena_pkg;

   localparam int unsigned ESTADO_W              = 4;
   localparam int unsigned TIMEOUT_CICLOS_PADRAO = 3_000_000;
   localparam int unsigned TIMEOUT_BITS_PADRAO   = 22;

   typedef enum logic [ESTADO_W-1:0] {
      ST_INICIAL             = 4'd0,
      ST_PREPARACAO          = 4'd1,
      ST_MEDICAO             = 4'd2,
      ST_AGUARDA_MEDIDA      = 4'd3,
      ST_TRANSMISSAO         = 4'd4,
      ST_AGUARDA_TRANSMISSAO = 4'd5,
      ST_PROXIMO             = 4'd6,
      ST_FINAL               = 4'd7,
      ST_ERRO                = 4'd15
   } estado_t;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with async and sync clear; saturates at M-1 instead of wrapping.
// fim flags the terminal count.
module contador_m #(
   parameter int unsigned M = 100,
   parameter int unsigned N = 7
) (
   input  logic clock,
   input  logic zera_as,
   input  logic zera_s,
   input  logic conta,
   output logic fim
);

   logic [N-1:0] q;

   always_ff @(posedge clock or posedge zera_as) begin
      if (zera_as) begin
         q <= '0;
      end else if (zera_s) begin
         q <= '0;
      end else if (conta && (q != N'(M - 1))) begin
         q <= q + N'(1);
      end
   end

   assign fim = (q == N'(M - 1));

endmodule

// File: rtl/trena_uc.sv
// Control unit: clear counter, trigger one measurement, send four ASCII characters,
// pulse pronto; a watchdog aborts to erro if the sensor never answers.
module trena_uc
   import trena_pkg::*;
#(
   parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
   parameter int unsigned TIMEOUT_BITS   = TIMEOUT_BITS_PADRAO
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                mensurar,
   input  logic                pronto_medida,
   input  logic                pronto_transmissao,
   input  logic                fim_serial,
   output logic                zera,
   output logic                medir,
   output logic                partida_serial,
   output logic                conta_ascii,
   output logic                pronto,
   output logic                erro,
   output logic [ESTADO_W-1:0] db_estado
);

   estado_t estado;
   estado_t proximo_estado;
   logic    aguardando;
   logic    timeout;

   assign aguardando = (estado == ST_AGUARDA_MEDIDA);

   // Watchdog runs only while waiting for the sensor and is cleared everywhere else.
   contador_m #(
      .M (TIMEOUT_CICLOS),
      .N (TIMEOUT_BITS)
   ) u_watchdog (
      .clock   (clock),
      .zera_as (reset),
      .zera_s  (!aguardando),
      .conta   (aguardando),
      .fim     (timeout)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= ST_INICIAL;
      end else begin
         estado <= proximo_estado;
      end
   end

   // A result arriving on the terminal watchdog cycle takes priority over the timeout.
   always_comb begin
      proximo_estado = ST_INICIAL;
      case (estado)
         ST_INICIAL:             proximo_estado = mensurar ? ST_PREPARACAO : ST_INICIAL;
         ST_PREPARACAO:          proximo_estado = ST_MEDICAO;
         ST_MEDICAO:             proximo_estado = ST_AGUARDA_MEDIDA;
         ST_AGUARDA_MEDIDA: begin
            if (pronto_medida) begin
               proximo_estado = ST_TRANSMISSAO;
            end else if (timeout) begin
               proximo_estado = ST_ERRO;
            end else begin
               proximo_estado = ST_AGUARDA_MEDIDA;
            end
         end
         ST_TRANSMISSAO:         proximo_estado = ST_AGUARDA_TRANSMISSAO;
         ST_AGUARDA_TRANSMISSAO: begin
            if (pronto_transmissao) begin
               proximo_estado = fim_serial ? ST_FINAL : ST_PROXIMO;
            end else begin
               proximo_estado = ST_AGUARDA_TRANSMISSAO;
            end
         end
         ST_PROXIMO:             proximo_estado = ST_TRANSMISSAO;
         ST_FINAL:               proximo_estado = ST_INICIAL;
         ST_ERRO:                proximo_estado = mensurar ? ST_PREPARACAO : ST_ERRO;
         default:                proximo_estado = ST_INICIAL;
      endcase
   end

   // Moore output decode from the state register.
   always_comb begin
      zera           = 1'b0;
      medir          = 1'b0;
      partida_serial = 1'b0;
      conta_ascii    = 1'b0;
      pronto         = 1'b0;
      erro           = 1'b0;
      case (estado)
         ST_PREPARACAO:  zera           = 1'b1;
         ST_MEDICAO:     medir          = 1'b1;
         ST_TRANSMISSAO: partida_serial = 1'b1;
         ST_PROXIMO:     conta_ascii    = 1'b1;
         ST_FINAL:       pronto         = 1'b1;
         ST_ERRO:        erro           = 1'b1;
         default:        ;
      endcase
   end

   assign db_estado = estado;

endmodule

// File: tb/tb_trena_uc.sv
// Directed-plus-random bench for trena_uc with a short watchdog (20 cycles).
module tb_trena_uc;

   localparam int unsigned TOUT = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       mensurar = 1'b0;
   logic       pronto_medida = 1'b0;
   logic       pronto_transmissao = 1'b0;
   logic       fim_serial = 1'b0;
   logic       zera, medir, partida_serial, conta_ascii, pronto, erro;
   logic [3:0] db_estado;

   int compared = 0;
   int mismatched = 0;
   int n_zera = 0, n_medir = 0, n_partida = 0, n_conta = 0, n_pronto = 0, n_erro = 0;

   trena_uc #(.TIMEOUT_CICLOS(TOUT), .TIMEOUT_BITS(5)) dut (
      .clock              (clock),
      .reset              (reset),
      .mensurar           (mensurar),
      .pronto_medida      (pronto_medida),
      .pronto_transmissao (pronto_transmissao),
      .fim_serial         (fim_serial),
      .zera               (zera),
      .medir              (medir),
      .partida_serial     (partida_serial),
      .conta_ascii        (conta_ascii),
      .pronto             (pronto),
      .erro               (erro),
      .db_estado          (db_estado)
   );

   always #5 clock = ~clock;

   // Pulse tallies sampled mid-cycle.
   always @(negedge clock) begin
      if (zera)           n_zera    <= n_zera + 1;
      if (medir)          n_medir   <= n_medir + 1;
      if (partida_serial) n_partida <= n_partida + 1;
      if (conta_ascii)    n_conta   <= n_conta + 1;
      if (pronto)         n_pronto  <= n_pronto + 1;
      if (erro)           n_erro    <= n_erro + 1;
   end

   localparam logic [7:0] O_NONE = 8'h00, O_ZERA = 8'h20, O_MEDIR = 8'h10, O_PART = 8'h08,
                          O_CONTA = 8'h04, O_PRONTO = 8'h02, O_ERRO = 8'h01;

   function automatic logic [7:0] outs();
      return {2'b00, zera, medir, partida_serial, conta_ascii, pronto, erro};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [7:0] exp_out, input logic [3:0] exp_st);
      chk({tag, "_out"}, outs(), exp_out);
      chk({tag, "_st"}, {4'b0, db_estado}, {4'b0, exp_st});
   endtask

   // mensurar at cycle N: zera N+1, medir N+2, waiting from N+3.
   task automatic start(input bit hold);
      mensurar = 1'b1;
      tick();
      mensurar = hold;
      chk_state("start_zera", O_ZERA, 4'd1);
      tick();
      chk_state("start_medir", O_MEDIR, 4'd2);
      tick();
      chk_state("start_wait", O_NONE, 4'd3);
   endtask

   // Waits d cycles in the measurement wait (with ignored noise), then delivers the result.
   task automatic measure(input int d, input bit hold);
      repeat (d) begin
         pronto_transmissao = 1'($urandom);
         fim_serial = 1'($urandom);
         mensurar = hold ? 1'b1 : 1'($urandom);
         tick();
      end
      pronto_transmissao = 1'b0;
      mensurar = hold;
      pronto_medida = 1'b1;
      tick();
      pronto_medida = 1'b0;
      chk_state("meas_part", O_PART, 4'd4);
   endtask

   // Four characters; fim_serial only on the last completion.
   task automatic run_chars(input bit hold);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_state("chr_wait", O_NONE, 4'd5);
         repeat ($urandom_range(0, 4)) begin
            fim_serial = 1'($urandom);
            pronto_medida = 1'($urandom);
            mensurar = hold ? 1'b1 : 1'($urandom);
            tick();
         end
         pronto_medida = 1'b0;
         mensurar = hold;
         pronto_transmissao = 1'b1;
         fim_serial = (i == 3);
         tick();
         pronto_transmissao = 1'b0;
         fim_serial = 1'($urandom);
         if (i < 3) begin
            chk_state("chr_conta", O_CONTA, 4'd6);
            tick();
            chk_state("chr_part", O_PART, 4'd4);
         end else begin
            chk_state("chr_pronto", O_PRONTO, 4'd7);
         end
      end
      fim_serial = 1'b0;
   endtask

   initial begin
      int s_zera, s_medir, s_part, s_conta, s_pronto, s_erro;

      // Reset state
      #2;
      chk_state("rst_hold", O_NONE, 4'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk_state("rst_idle", O_NONE, 4'd0);

      // Full successful cycles with random latencies
      for (int r = 0; r < 3; r++) begin
         s_zera = n_zera; s_medir = n_medir; s_part = n_partida;
         s_conta = n_conta; s_pronto = n_pronto; s_erro = n_erro;
         start(1'b0);
         measure(int'($urandom_range(0, TOUT - 2)), 1'b0);
         run_chars(1'b0);
         tick();
         chk_state("cyc_done", O_NONE, 4'd0);
         chk("cnt_zera",   8'(n_zera - s_zera),      8'd1);
         chk("cnt_medir",  8'(n_medir - s_medir),    8'd1);
         chk("cnt_part",   8'(n_partida - s_part),   8'd4);
         chk("cnt_conta",  8'(n_conta - s_conta),    8'd3);
         chk("cnt_pronto", 8'(n_pronto - s_pronto),  8'd1);
         chk("cnt_erro",   8'(n_erro - s_erro),      8'd0);
      end

      // Timeout: TOUT cycles in the wait state without a result
      start(1'b0);
      for (int k = 1; k < int'(TOUT); k++) begin
         tick();
         chk_state("tout_wait", O_NONE, 4'd3);
      end
      tick();
      chk_state("tout_erro", O_ERRO, 4'd15);
      repeat (3) begin
         pronto_medida = 1'($urandom);
         pronto_transmissao = 1'($urandom);
         tick();
         chk_state("erro_hold", O_ERRO, 4'd15);
      end
      pronto_medida = 1'b0;
      pronto_transmissao = 1'b0;
      mensurar = 1'b1;
      tick();
      mensurar = 1'b0;
      chk_state("erro_exit", O_ZERA, 4'd1);

      // Result on the terminal watchdog cycle wins
      s_erro = n_erro;
      tick();
      chk_state("tc_medir", O_MEDIR, 4'd2);
      tick();
      chk_state("tc_wait", O_NONE, 4'd3);
      measure(int'(TOUT) - 1, 1'b0);
      run_chars(1'b0);
      tick();
      chk_state("tc_done", O_NONE, 4'd0);
      chk("tc_no_erro", 8'(n_erro - s_erro), 8'd0);

      // mensurar ignored while transmitting, then reset mid-transmission
      s_zera = n_zera;
      start(1'b0);
      measure(3, 1'b0);
      tick();
      chk_state("ign_wait", O_NONE, 4'd5);
      mensurar = 1'b1;
      tick();
      mensurar = 1'b0;
      chk_state("ign_mens", O_NONE, 4'd5);
      tick();
      chk("ign_zera", 8'(n_zera - s_zera), 8'd1);
      reset = 1'b1;
      #1;
      chk_state("rst_mid", O_NONE, 4'd0);
      tick();
      reset = 1'b0;
      tick();
      chk_state("rst_after", O_NONE, 4'd0);

      // mensurar held high: new medir three cycles after pronto
      start(1'b1);
      measure(int'($urandom_range(0, 10)), 1'b1);
      run_chars(1'b1);
      tick();
      chk_state("hold_idle", O_NONE, 4'd0);
      tick();
      chk_state("hold_zera", O_ZERA, 4'd1);
      tick();
      chk_state("hold_medir", O_MEDIR, 4'd2);
      mensurar = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk_state("end_idle", O_NONE, 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
